veda_mem_bank: RTL and testbench

- Parametrised successor to the single-port 32x32 scratch memory.
- Provides one byte-enabled write port and two independent read ports, each with a fixed 2-cycle registered read latency.
- Adds a mode-based write lock and a sequential clear engine that zeroes one entry per cycle after reset.
- Sits between the interpreter datapath and its operand/result storage.

---
 rtl/veda_mem_bank.sv | 170 +++++++++++++++++
 tb/tb_veda_mem_bank.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/veda_mem_bank.sv
// Scratch memory bank: one byte-enabled write port, two 2-cycle registered read ports,
// a mode-based write lock, and a clear engine that zeroes one word per cycle after reset.
module veda_mem_bank #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mode,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wbe,
    input  logic                  rd_en_a,
    input  logic [ADDR_W-1:0]     raddr_a,
    output logic [DATA_W-1:0]     rdata_a,
    output logic                  rvalid_a,
    input  logic                  rd_en_b,
    input  logic [ADDR_W-1:0]     raddr_b,
    output logic [DATA_W-1:0]     rdata_b,
    output logic                  rvalid_b,
    output logic                  busy,
    output logic                  wr_err
);

    localparam int BE_W = DATA_W / 8;
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic                clr_en;

    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                waddr_ok;
    logic                wr_hit;
    logic                wr_acc;
    logic                wr_rej;
    logic [DATA_W-1:0]   wr_word;
    logic [DATA_W-1:0]   rd_word_a, rd_word_b;
    logic                rd_acc_a, rd_acc_b;

    logic                s1_v_a_q, s1_v_b_q;
    logic [DATA_W-1:0]   s1_d_a_q, s1_d_b_q;
    logic                rvalid_a_q, rvalid_b_q;
    logic [DATA_W-1:0]   rdata_a_q, rdata_b_q;
    logic                wr_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        clr_en  = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clr_en = 1'b1;
                ptr_d  = ptr_q + 1'b1;
                if (ptr_q == PTR_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    assign busy = (state_q == ST_CLEAR);

    // A write with no byte lanes enabled is a silent no-op, never an error.
    assign waddr_ok = ({1'b0, waddr} < DEPTH_X);
    assign wr_hit   = we && (wbe != '0);
    assign wr_acc   = wr_hit && !mode && !busy && waddr_ok;
    assign wr_rej   = wr_hit && (mode || busy || !waddr_ok);

    always_comb begin
        wr_word = '0;
        if (waddr_ok) begin
            wr_word = mem_q[waddr];
        end
        for (int i = 0; i < BE_W; i++) begin
            if (wbe[i]) begin
                wr_word[8*i +: 8] = wdata[8*i +: 8];
            end
        end
    end

    // Write-first: a read hitting the address being written sees the merged word.
    always_comb begin
        rd_word_a = '0;
        rd_word_b = '0;
        if ({1'b0, raddr_a} < DEPTH_X) begin
            rd_word_a = (wr_acc && (raddr_a == waddr)) ? wr_word : mem_q[raddr_a];
        end
        if ({1'b0, raddr_b} < DEPTH_X) begin
            rd_word_b = (wr_acc && (raddr_b == waddr)) ? wr_word : mem_q[raddr_b];
        end
    end

    assign rd_acc_a = rd_en_a && !busy;
    assign rd_acc_b = rd_en_b && !busy;

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (clr_en) begin
                mem_q[ptr_q] <= '0;
            end else if (wr_acc) begin
                mem_q[waddr] <= wr_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_v_a_q   <= 1'b0;
            s1_v_b_q   <= 1'b0;
            s1_d_a_q   <= '0;
            s1_d_b_q   <= '0;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
            rdata_a_q  <= '0;
            rdata_b_q  <= '0;
            wr_err_q   <= 1'b0;
        end else begin
            s1_v_a_q   <= rd_acc_a;
            s1_v_b_q   <= rd_acc_b;
            if (rd_acc_a) begin
                s1_d_a_q <= rd_word_a;
            end
            if (rd_acc_b) begin
                s1_d_b_q <= rd_word_b;
            end
            rvalid_a_q <= s1_v_a_q;
            rvalid_b_q <= s1_v_b_q;
            if (s1_v_a_q) begin
                rdata_a_q <= s1_d_a_q;
            end
            if (s1_v_b_q) begin
                rdata_b_q <= s1_d_b_q;
            end
            wr_err_q   <= wr_rej;
        end
    end

    assign rdata_a  = rdata_a_q;
    assign rvalid_a = rvalid_a_q;
    assign rdata_b  = rdata_b_q;
    assign rvalid_b = rvalid_b_q;
    assign wr_err   = wr_err_q;

endmodule

// File: tb/tb_veda_mem_bank.sv
// Bench for veda_mem_bank: a cycle model predicts busy/wr_err/rvalid every cycle and
// queues expected read data, which is popped and compared whenever a port returns data.
module tb_veda_mem_bank;

    localparam int DW    = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int BW    = DW / 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            mode;
    logic            we;
    logic [AW-1:0]   waddr;
    logic [DW-1:0]   wdata;
    logic [BW-1:0]   wbe;
    logic            rd_en_a;
    logic [AW-1:0]   raddr_a;
    logic [DW-1:0]   rdata_a;
    logic            rvalid_a;
    logic            rd_en_b;
    logic [AW-1:0]   raddr_b;
    logic [DW-1:0]   rdata_b;
    logic            rvalid_b;
    logic            busy;
    logic            wr_err;

    always #5 clk = ~clk;

    veda_mem_bank #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk      (clk),
        .reset    (reset),
        .mode     (mode),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .wbe      (wbe),
        .rd_en_a  (rd_en_a),
        .raddr_a  (raddr_a),
        .rdata_a  (rdata_a),
        .rvalid_a (rvalid_a),
        .rd_en_b  (rd_en_b),
        .raddr_b  (raddr_b),
        .rdata_b  (rdata_b),
        .rvalid_b (rvalid_b),
        .busy     (busy),
        .wr_err   (wr_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] mm [DEPTH];
    bit            m_busy;
    int            m_ptr;
    bit            m_s1v_a, m_s1v_b, m_rv_a, m_rv_b, m_err;
    logic [DW-1:0] m_last_a, m_last_b;
    logic [DW-1:0] q_a [$];
    logic [DW-1:0] q_b [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                            input logic [BW-1:0] be);
        logic [DW-1:0] r;
        r = old;
        for (int i = 0; i < BW; i++) begin
            if (be[i]) r[8*i +: 8] = d[8*i +: 8];
        end
        return r;
    endfunction

    task automatic tick();
        if (reset) begin
            m_busy = 1; m_ptr = 0;
            m_s1v_a = 0; m_s1v_b = 0; m_rv_a = 0; m_rv_b = 0; m_err = 0;
            m_last_a = '0; m_last_b = '0;
            q_a.delete(); q_b.delete();
        end else begin
            m_rv_a = m_s1v_a;
            m_rv_b = m_s1v_b;
            m_err  = we && (wbe != '0) && (mode || m_busy || int'(waddr) >= DEPTH);
            if (we && !mode && !m_busy && int'(waddr) < DEPTH) mm[waddr] = merge(mm[waddr], wdata, wbe);
            m_s1v_a = rd_en_a && !m_busy;
            m_s1v_b = rd_en_b && !m_busy;
            if (m_s1v_a) q_a.push_back(int'(raddr_a) < DEPTH ? mm[raddr_a] : '0);
            if (m_s1v_b) q_b.push_back(int'(raddr_b) < DEPTH ? mm[raddr_b] : '0);
            if (m_busy) begin
                mm[m_ptr] = '0;
                if (m_ptr == DEPTH - 1) m_busy = 0;
                m_ptr++;
            end
        end
        @(posedge clk);
        #1;
        check("busy", busy, m_busy);
        check("wr_err", wr_err, m_err);
        check("rvalid_a", rvalid_a, m_rv_a);
        check("rvalid_b", rvalid_b, m_rv_b);
        if (rvalid_a) begin
            check("sb_a_nonempty", q_a.size() != 0, 1);
            if (q_a.size() != 0) m_last_a = q_a.pop_front();
        end
        if (rvalid_b) begin
            check("sb_b_nonempty", q_b.size() != 0, 1);
            if (q_b.size() != 0) m_last_b = q_b.pop_front();
        end
        check("rdata_a", rdata_a, m_last_a);
        check("rdata_b", rdata_b, m_last_b);
    endtask

    task automatic idle();
        we = 0; wbe = '0; wdata = '0; waddr = '0;
        rd_en_a = 0; rd_en_b = 0; raddr_a = '0; raddr_b = '0;
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d, input logic [BW-1:0] be);
        idle();
        we = 1; waddr = AW'(a); wdata = d; wbe = be;
        tick();
    endtask

    task automatic rd_a(input int a);
        idle();
        rd_en_a = 1; raddr_a = AW'(a);
        tick();
    endtask

    task automatic drain();
        idle();
        repeat (3) tick();
    endtask

    task automatic wait_clear(input int first);
        int cnt;
        cnt = first;
        idle();
        do begin
            tick();
            cnt++;
        end while (busy && cnt < 100);
        check("busy_edges", cnt, DEPTH);
    endtask

    initial begin
        mode = 0;
        idle();
        reset = 1;
        tick();
        reset = 0;
        wait_clear(0);

        for (int i = 0; i < DEPTH; i++) rd_a(i);
        drain();

        wr(5, 32'hDEADBEEF, 4'hF);
        wr(5, 32'h00001122, 4'b0011);
        idle(); tick();
        rd_a(5);
        drain();
        check("addr5_merged", m_last_a, 32'hDEAD1122);

        mode = 1;
        wr(7, 32'h12345678, 4'hF);
        mode = 0;
        idle(); tick();
        rd_a(7);
        drain();

        idle();
        we = 1; waddr = 5'd9; wdata = 32'hCAFEF00D; wbe = 4'hF;
        rd_en_a = 1; raddr_a = 5'd9; rd_en_b = 1; raddr_b = 5'd9;
        tick();
        drain();

        wr(3, 32'h55555555, 4'h0);

        for (int i = 0; i < 4; i++) wr(i, 32'h10 + i, 4'hF);
        for (int i = 0; i < 4; i++) rd_a(i);
        drain();

        for (int n = 0; n < 300; n++) begin
            mode    = ($urandom_range(0, 3) == 0);
            we      = $urandom_range(0, 1);
            waddr   = AW'($urandom_range(0, DEPTH - 1));
            wdata   = $urandom;
            wbe     = BW'($urandom_range(0, (1 << BW) - 1));
            rd_en_a = $urandom_range(0, 1);
            raddr_a = AW'($urandom_range(0, DEPTH - 1));
            rd_en_b = $urandom_range(0, 1);
            raddr_b = AW'($urandom_range(0, DEPTH - 1));
            tick();
        end
        mode = 0;
        drain();

        reset = 1; tick(); reset = 0;
        idle();
        repeat (20) tick();
        reset = 1; tick(); reset = 0;
        wr(3, 32'hA5A5A5A5, 4'hF);
        rd_en_a = 1; raddr_a = 5'd3;
        wait_clear(1);
        rd_a(3);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule
